// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the trace record extractor slice:
//   - ASCII control characters and digit/hex ranges of the CPU trace format
//   - format_type verdict codes driven by the upstream format checker
//   - field tracker state enum
//   - packed record layout (bit offsets) and character helper functions
// Packed record, LSB first:
//   data[31:0] | reg_ovf | reg[4:0] | addr[31:0] | pc[31:0] | time[TIME_W-1:0] | kind
// -----------------------------------------------------------------------------
package trace_pkg;

    // Trace line delimiters
    localparam logic [7:0] CH_CARET  = 8'h5E;  // '^' start of line
    localparam logic [7:0] CH_AT     = 8'h40;  // '@' time -> pc
    localparam logic [7:0] CH_COLON  = 8'h3A;  // ':' pc -> separator
    localparam logic [7:0] CH_STAR   = 8'h2A;  // '*' memory address follows
    localparam logic [7:0] CH_DOLLAR = 8'h24;  // '$' register number follows
    localparam logic [7:0] CH_LT     = 8'h3C;  // '<' first half of "<="
    localparam logic [7:0] CH_EQ     = 8'h3D;  // '=' data follows
    localparam logic [7:0] CH_HASH   = 8'h23;  // '#' end of line

    // Digit classes (hex digits are lowercase only in this trace format)
    localparam logic [7:0] CH_0 = 8'h30;
    localparam logic [7:0] CH_9 = 8'h39;
    localparam logic [7:0] CH_A = 8'h61;
    localparam logic [7:0] CH_F = 8'h66;

    // Checker verdicts; 2'b11 carries no meaning and is treated as FMT_NONE
    localparam logic [1:0] FMT_NONE = 2'b00;
    localparam logic [1:0] FMT_REG  = 2'b01;
    localparam logic [1:0] FMT_MEM  = 2'b10;

    typedef enum logic [2:0] {
        F_IDLE,
        F_TIME,
        F_PC,
        F_SEP,
        F_ADDR,
        F_REG,
        F_WAIT,
        F_DATA
    } field_state_e;

    // Packed record bit offsets; time is TIME_W wide, kind sits just above it
    localparam int REC_DATA_OFS = 0;
    localparam int REC_OVF_OFS  = 32;
    localparam int REC_REG_OFS  = 33;
    localparam int REC_ADDR_OFS = 38;
    localparam int REC_PC_OFS   = 70;
    localparam int REC_TIME_OFS = 102;

    function automatic int rec_width(input int time_w);
        return REC_TIME_OFS + time_w + 1;
    endfunction

    function automatic logic is_dec(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

    function automatic logic is_hex(input logic [7:0] c);
        return is_dec(c) || ((c >= CH_A) && (c <= CH_F));
    endfunction

    // Numeric value of a decimal or lowercase hex digit
    function automatic logic [3:0] digit_val(input logic [7:0] c);
        logic [7:0] v;
        v = is_dec(c) ? (c - CH_0) : (c - CH_A + 8'd10);
        return v[3:0];
    endfunction

endpackage

// File: rtl/trace_record_extractor_if.sv
// -----------------------------------------------------------------------------
// trace_record_extractor_if
// Record output port of the trace record extractor (valid/ready handshake).
//   rec_valid    record available          (master -> slave)
//   rec_ready    consumer accepts record   (slave -> master)
//   rec_kind     0 register write, 1 memory write
//   rec_time     decimal time field, binary, TIME_W bits
//   rec_pc       PC field
//   rec_addr     memory address (zero for register writes)
//   rec_reg      register number low 5 bits (zero for memory writes)
//   rec_reg_ovf  register number parsed above 31
//   rec_data     written data
//   rec_overflow sticky: a committed record was lost
// -----------------------------------------------------------------------------
interface trace_record_extractor_if #(
    parameter int TIME_W = 14
);
    logic              rec_valid;
    logic              rec_ready;
    logic              rec_kind;
    logic [TIME_W-1:0] rec_time;
    logic [31:0]       rec_pc;
    logic [31:0]       rec_addr;
    logic [4:0]        rec_reg;
    logic              rec_reg_ovf;
    logic [31:0]       rec_data;
    logic              rec_overflow;

    modport master (
        output rec_valid, rec_kind, rec_time, rec_pc, rec_addr,
               rec_reg, rec_reg_ovf, rec_data, rec_overflow,
        input  rec_ready
    );

    modport slave (
        input  rec_valid, rec_kind, rec_time, rec_pc, rec_addr,
               rec_reg, rec_reg_ovf, rec_data, rec_overflow,
        output rec_ready
    );
endinterface

// File: rtl/trace_rec_fifo.sv
// -----------------------------------------------------------------------------
// trace_rec_fifo
// Record-wide synchronous FIFO with count-based full/empty. Only compiled when
// TRACE_REC_FIFO_EN is defined (the only configuration that instantiates it).
//   clk, reset  clock, synchronous active-high reset
//   push, din   write request and record; ignored when full unless popping too
//   pop         read request (head advances); ignored when empty
//   dout        head record, all zeros while empty
//   valid       FIFO not empty
//   full        FIFO holds DEPTH records
// -----------------------------------------------------------------------------
`ifdef TRACE_REC_FIFO_EN
module trace_rec_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    // A simultaneous pop frees the slot this push needs, so full does not block it
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem[rd_ptr] : '0;

    // NOTE: the storage array has no reset; only pointers and count do, and
    // dout is masked to zero while empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
`endif

// File: rtl/trace_record_extractor.sv
// -----------------------------------------------------------------------------
// trace_record_extractor
// Snoops the ASCII CPU trace stream alongside the format checker, shadows the
// field values of the line in flight and, on the checker's format_type verdict
// (the cycle after '#'), commits them as a binary record on a valid/ready port.
// No format validation is done here; the checker's verdict is trusted.
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   char         ASCII character, one per cycle
//   format_type  checker verdict: 01 reg write, 10 mem write, 00/11 none
//   rec          record port (trace_record_extractor_if.master)
// Parameters:
//   TIME_W       width of the decimal time accumulator / rec_time
//   REC_DEPTH    record FIFO depth (power of 2, >= 2), used with the FIFO only
// Configuration macro TRACE_REC_FIFO_EN:
//   undefined  single output slot; a commit while the slot is held is dropped
//   defined    REC_DEPTH-entry FIFO (trace_rec_fifo), head drives rec_*
// -----------------------------------------------------------------------------
module trace_record_extractor
    import trace_pkg::*;
#(
    parameter int TIME_W    = 14,
    parameter int REC_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      char,
    input  logic [1:0]                      format_type,
    trace_record_extractor_if.master        rec
);
    localparam int REC_W = rec_width(TIME_W);

    if (REC_DEPTH < 2 || (REC_DEPTH & (REC_DEPTH - 1)) != 0) begin : g_bad_rec_depth
        $error("REC_DEPTH must be a power of 2 and at least 2");
    end

    field_state_e      state;
    logic [TIME_W-1:0] time_sh;
    logic [31:0]       pc_sh;
    logic [31:0]       addr_sh;
    logic [9:0]        reg_sh;
    logic [31:0]       data_sh;

    logic              commit;
    logic              commit_kind;
    logic [REC_W-1:0]  rec_in;
    logic [REC_W-1:0]  head;
    logic              head_valid;
    logic              pop;
    logic              drop;
    logic              overflow_q;

    // ---------------------------------------------------------------- tracker
    // NOTE: shadows update with nonblocking assignments, so a commit on the same
    // edge as a '^' still captures the finished line before the clear lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= F_IDLE;
            time_sh <= '0;
            pc_sh   <= '0;
            addr_sh <= '0;
            reg_sh  <= '0;
            data_sh <= '0;
        end else if (char == CH_CARET) begin
            state   <= F_TIME;
            time_sh <= '0;
            pc_sh   <= '0;
            addr_sh <= '0;
            reg_sh  <= '0;
            data_sh <= '0;
        end else if (char == CH_HASH) begin
            state <= F_IDLE;
        end else begin
            case (state)
                F_TIME: begin
                    if (char == CH_AT) begin
                        state <= F_PC;
                    end else if (is_dec(char)) begin
                        time_sh <= time_sh * TIME_W'(10) + TIME_W'(digit_val(char));
                    end
                end
                F_PC: begin
                    if (char == CH_COLON) begin
                        state <= F_SEP;
                    end else if (is_hex(char)) begin
                        pc_sh <= {pc_sh[27:0], digit_val(char)};
                    end
                end
                F_SEP: begin
                    if (char == CH_STAR) begin
                        state <= F_ADDR;
                    end else if (char == CH_DOLLAR) begin
                        state <= F_REG;
                    end
                end
                F_ADDR, F_REG, F_WAIT: begin
                    if (char == CH_LT) begin
                        state <= F_WAIT;
                    end else if (char == CH_EQ) begin
                        state <= F_DATA;
                    end else if (state == F_ADDR && is_hex(char)) begin
                        addr_sh <= {addr_sh[27:0], digit_val(char)};
                    end else if (state == F_REG && is_dec(char)) begin
                        reg_sh <= reg_sh * 10'd10 + 10'(digit_val(char));
                    end
                end
                F_DATA: begin
                    if (is_hex(char)) begin
                        data_sh <= {data_sh[27:0], digit_val(char)};
                    end
                end
                default: ;
            endcase
        end
    end

    // ----------------------------------------------------------------- commit
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        commit      = 1'b0;
        commit_kind = 1'b0;
        case (format_type)
            FMT_REG:  commit = 1'b1;
            FMT_MEM:  begin
                commit      = 1'b1;
                commit_kind = 1'b1;
            end
            FMT_NONE: commit = 1'b0;
            default:  commit = 1'b0;
        endcase
    end

    // Fields that do not belong to the record kind are forced to zero
    assign rec_in = {commit_kind,
                     time_sh,
                     pc_sh,
                     commit_kind ? addr_sh : 32'd0,
                     commit_kind ? 5'd0 : reg_sh[4:0],
                     !commit_kind && (reg_sh > 10'd31),
                     data_sh};

    assign pop = head_valid && rec.rec_ready;

    // ---------------------------------------------------------- record store
`ifdef TRACE_REC_FIFO_EN
    logic fifo_full;

    trace_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (REC_DEPTH)
    ) u_rec_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (commit),
        .din   (rec_in),
        .pop   (pop),
        .dout  (head),
        .valid (head_valid),
        .full  (fifo_full)
    );

    assign drop = commit && fifo_full && !pop;
`else
    // Single slot: a commit reloads it when empty or when the held record is
    // leaving this cycle, so back-to-back records flow without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_valid <= 1'b0;
            head       <= '0;
        end else if (commit && (!head_valid || rec.rec_ready)) begin
            head_valid <= 1'b1;
            head       <= rec_in;
        end else if (pop) begin
            head_valid <= 1'b0;
            head       <= '0;
        end
    end

    assign drop = commit && head_valid && !rec.rec_ready;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign rec.rec_valid    = head_valid;
    assign rec.rec_kind     = head[REC_TIME_OFS + TIME_W];
    assign rec.rec_time     = head[REC_TIME_OFS +: TIME_W];
    assign rec.rec_pc       = head[REC_PC_OFS   +: 32];
    assign rec.rec_addr     = head[REC_ADDR_OFS +: 32];
    assign rec.rec_reg      = head[REC_REG_OFS  +: 5];
    assign rec.rec_reg_ovf  = head[REC_OVF_OFS];
    assign rec.rec_data     = head[REC_DATA_OFS +: 32];
    assign rec.rec_overflow = overflow_q;

endmodule

// File: tb/tb_trace_record_extractor.sv
// -----------------------------------------------------------------------------
// tb_trace_record_extractor
// Builds trace lines from chosen field values, streams them one char per cycle
// with the checker verdict on the cycle after '#', and predicts records from the
// chosen values (decimal value mod 2^TIME_W, last 8 hex nibbles, register number
// mod 1024). A record queue of capacity 1 (or REC_DEPTH with TRACE_REC_FIFO_EN)
// predicts rec_valid/rec_*/rec_overflow, compared on every falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trace_record_extractor;
    localparam int TIME_W    = 14;
    localparam int REC_DEPTH = 4;
`ifdef TRACE_REC_FIFO_EN
    localparam int CAP = REC_DEPTH;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic              kind;
        logic [TIME_W-1:0] t;
        logic [31:0]       pc;
        logic [31:0]       addr;
        logic [4:0]        rg;
        logic              rg_ovf;
        logic [31:0]       data;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] char_in = 8'h20;
    logic [1:0] fmt = 2'b00;

    trace_record_extractor_if #(.TIME_W(TIME_W)) rif ();

    trace_record_extractor #(
        .TIME_W    (TIME_W),
        .REC_DEPTH (REC_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char_in),
        .format_type (fmt),
        .rec         (rif.master)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;
    int   ready_mode = 0;   // 0 hold low, 1 hold high, 2 random
    rec_t cur_rec = '0;     // record the model commits when fmt carries a verdict

    // ---------------------------------------------------------- model
    rec_t mq[$];
    logic m_ovf = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (mq.size() > 0 && rif.rec_ready) void'(mq.pop_front());
            if (fmt == 2'b01 || fmt == 2'b10) begin
                if (mq.size() < CAP) mq.push_back(cur_rec);
                else m_ovf = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------- checking
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic rec_t dut_rec();
        rec_t r;
        r.kind   = rif.rec_kind;
        r.t      = rif.rec_time;
        r.pc     = rif.rec_pc;
        r.addr   = rif.rec_addr;
        r.rg     = rif.rec_reg;
        r.rg_ovf = rif.rec_reg_ovf;
        r.data   = rif.rec_data;
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            rec_t a;
            rec_t e;
            a = dut_rec();
            e = (mq.size() > 0) ? mq[0] : '0;
            check("rec_valid", rif.rec_valid, mq.size() > 0);
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL rec_fields: got k%0d t%0d pc %h addr %h reg %0d ovf %0d data %h expected k%0d t%0d pc %h addr %h reg %0d ovf %0d data %h (t=%0t)",
                         a.kind, a.t, a.pc, a.addr, a.rg, a.rg_ovf, a.data,
                         e.kind, e.t, e.pc, e.addr, e.rg, e.rg_ovf, e.data, $time);
            end
            check("rec_overflow", rif.rec_overflow, m_ovf);
        end
    end

    // ---------------------------------------------------------- stimulus
    logic [7:0] q_c[$];
    logic [1:0] q_f[$];
    rec_t       q_r[$];
    logic [1:0] pend_f = 2'b00;
    rec_t       pend_r = '0;

    // The verdict of a finished line rides on the next character queued
    task automatic put(input logic [7:0] c);
        q_c.push_back(c);
        q_f.push_back(pend_f);
        q_r.push_back(pend_r);
        pend_f = 2'b00;
    endtask

    task automatic put_gap(input int n);
        for (int i = 0; i < n; i++) put(($urandom_range(0, 3) == 0) ? 8'h7A : 8'h20);
    endtask

    task automatic put_dec(input longint v, input int ndig);
        int dg[8];
        longint x;
        x = v;
        for (int i = 0; i < ndig; i++) begin
            dg[i] = int'(x % 10);
            x = x / 10;
        end
        for (int i = ndig - 1; i >= 0; i--) put(8'h30 + 8'(dg[i]));
    endtask

    task automatic put_hex(input logic [39:0] v, input int nnib);
        logic [3:0] n;
        for (int i = nnib - 1; i >= 0; i--) begin
            n = v[i*4 +: 4];
            put((n < 10) ? (8'h30 + 8'(n)) : (8'h61 + 8'(n) - 8'd10));
        end
    endtask

    function automatic logic [39:0] keep_nibs(input logic [39:0] v, input int n);
        logic [63:0] mask;
        mask = (64'd1 << (4 * n)) - 64'd1;
        return v & mask[39:0];
    endfunction

    task automatic gen_line(input bit mem, input longint tv, input int tdig,
                            input logic [39:0] pcv, input int pcn,
                            input int regv, input int rdig,
                            input logic [39:0] av, input int an,
                            input logic [39:0] dv, input int dn,
                            input logic [1:0] ft);
        rec_t e;
        logic [39:0] pcm, am, dm;
        pcm = keep_nibs(pcv, pcn);
        am  = keep_nibs(av, an);
        dm  = keep_nibs(dv, dn);
        put(8'h5E);
        put_dec(tv, tdig);
        put(8'h40);
        put_hex(pcm, pcn);
        put(8'h3A);
        put_gap($urandom_range(0, 2));
        if (mem) begin
            put(8'h2A);
            put_hex(am, an);
        end else begin
            put(8'h24);
            put_dec(longint'(regv), rdig);
        end
        put_gap($urandom_range(0, 2));
        put(8'h3C);
        put(8'h3D);
        put_gap($urandom_range(0, 2));
        put_hex(dm, dn);
        put(8'h23);
        e.kind   = mem;
        e.t      = TIME_W'(tv % (longint'(1) << TIME_W));
        e.pc     = pcm[31:0];
        e.addr   = mem ? am[31:0] : 32'd0;
        e.rg     = mem ? 5'd0 : 5'((regv % 1024) % 32);
        e.rg_ovf = mem ? 1'b0 : ((regv % 1024) > 31);
        e.data   = dm[31:0];
        pend_f = ft;
        pend_r = e;
    endtask

    task automatic cycle(input logic [7:0] c, input logic [1:0] f, input rec_t r);
        char_in = c;
        fmt     = f;
        cur_rec = r;
        case (ready_mode)
            0:       rif.rec_ready = 1'b0;
            1:       rif.rec_ready = 1'b1;
            default: rif.rec_ready = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(8'h20, 2'b00, '0);
    endtask

    task automatic run_stream();
        if (pend_f != 2'b00) put(8'h20);
        while (q_c.size() > 0) cycle(q_c.pop_front(), q_f.pop_front(), q_r.pop_front());
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!rif.rec_valid && k < 20) begin
            idle(1);
            k++;
        end
        check(name, rif.rec_valid, 1'b1);
    endtask

    task automatic drain();
        ready_mode = 1;
        idle(CAP + 3);
        ready_mode = 0;
    endtask

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    initial begin
        rif.rec_ready = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        chk_en = 1'b1;
        check("reset_valid", rif.rec_valid, 1'b0);
        check("reset_overflow", rif.rec_overflow, 1'b0);
        check("reset_time", rif.rec_time, 0);

        // Register write line
        ready_mode = 0;
        gen_line(0, 12, 2, 40'h3000, 8, 5, 1, 40'h0, 0, 40'habcd, 8, 2'b01);
        run_stream();
        wait_valid("l1_valid");
        check("l1_kind", rif.rec_kind, 1'b0);
        check("l1_time", rif.rec_time, 12);
        check("l1_pc",   rif.rec_pc, 32'h3000);
        check("l1_reg",  rif.rec_reg, 5);
        check("l1_data", rif.rec_data, 32'habcd);
        check("l1_addr", rif.rec_addr, 0);
        drain();

        // Memory write line at the 4-digit time limit
        gen_line(1, 9999, 4, 40'h300c, 8, 0, 0, 40'h10, 8, 40'hffffffff, 8, 2'b10);
        run_stream();
        wait_valid("l2_valid");
        check("l2_kind", rif.rec_kind, 1'b1);
        check("l2_time", rif.rec_time, 9999);
        check("l2_addr", rif.rec_addr, 32'h10);
        check("l2_data", rif.rec_data, 32'hffffffff);
        check("l2_reg",  rif.rec_reg, 0);
        drain();

        // Register number above 31
        gen_line(0, 7, 1, 40'h4, 1, 40, 2, 40'h0, 0, 40'h1, 1, 2'b01);
        run_stream();
        wait_valid("l3_valid");
        check("l3_reg", rif.rec_reg, 8);
        check("l3_reg_ovf", rif.rec_reg_ovf, 1'b1);
        drain();

        // Time wraps modulo 2^14, PC keeps only the last 8 nibbles
        gen_line(0, 20000, 5, 40'h123456789a, 10, 1, 1, 40'h0, 0, 40'h5, 1, 2'b01);
        run_stream();
        wait_valid("l4_valid");
        check("l4_time", rif.rec_time, 3616);
        check("l4_pc", rif.rec_pc, 32'h3456789a);
        drain();

        // Two lines back to back while the consumer stalls
        gen_line(0, 1, 1, 40'h1, 1, 1, 1, 40'h0, 0, 40'h1, 1, 2'b01);
        gen_line(1, 2, 1, 40'h2, 1, 0, 0, 40'h2, 1, 40'h2, 1, 2'b10);
        run_stream();
        idle(2);
        check("b2b_head_time", rif.rec_time, 1);
`ifdef TRACE_REC_FIFO_EN
        check("b2b_overflow", rif.rec_overflow, 1'b0);
        ready_mode = 1;
        idle(1);
        ready_mode = 0;
        check("b2b_second_time", rif.rec_time, 2);
`else
        check("b2b_overflow", rif.rec_overflow, 1'b1);
`endif
        drain();

        // Complete lines with no verdict, then a normal line
        gen_line(0, 3, 1, 40'h3, 1, 3, 1, 40'h0, 0, 40'h3, 1, 2'b00);
        gen_line(1, 4, 1, 40'h4, 1, 0, 0, 40'h4, 1, 40'h4, 1, 2'b11);
        run_stream();
        idle(3);
        check("nofmt_valid", rif.rec_valid, 1'b0);
        gen_line(0, 55, 2, 40'h55, 2, 6, 1, 40'h0, 0, 40'h66, 2, 2'b01);
        run_stream();
        wait_valid("after_nofmt_valid");
        check("after_nofmt_time", rif.rec_time, 55);
        check("after_nofmt_data", rif.rec_data, 32'h66);
        drain();

        // Reset in the middle of the data field
        put(8'h5E); put_dec(5, 1); put(8'h40); put_hex(40'h10, 2); put(8'h3A);
        put(8'h24); put_dec(3, 1); put(8'h3C); put(8'h3D); put_hex(40'hab, 2);
        run_stream();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("rst_mid_valid", rif.rec_valid, 1'b0);
        // A bare '#' after reset commits the cleared shadows
        put(8'h23);
        pend_f = 2'b01;
        pend_r = '0;
        run_stream();
        wait_valid("rst_zero_valid");
        check("rst_zero_data", rif.rec_data, 0);
        check("rst_zero_pc", rif.rec_pc, 0);
        drain();
        gen_line(1, 77, 2, 40'h7, 1, 0, 0, 40'h8, 1, 40'h9, 1, 2'b10);
        run_stream();
        wait_valid("rst_next_valid");
        check("rst_next_time", rif.rec_time, 77);
        drain();

        // Randomized lines, verdicts and consumer back-pressure
        ready_mode = 2;
        for (int n = 0; n < 80; n++) begin
            bit mem;
            int tdig, pcn, rdig, an, dn, sel;
            logic [1:0] ft;
            mem  = 1'($urandom_range(0, 1));
            tdig = $urandom_range(1, 5);
            pcn  = $urandom_range(1, 10);
            rdig = $urandom_range(1, 4);
            an   = $urandom_range(1, 10);
            dn   = $urandom_range(1, 10);
            sel  = $urandom_range(0, 9);
            ft   = (sel < 7) ? (mem ? 2'b10 : 2'b01) : ((sel == 8) ? 2'b11 : 2'b00);
            gen_line(mem, longint'($urandom_range(0, int'(pow10(tdig) - 1))), tdig,
                     {$urandom, $urandom}, pcn,
                     $urandom_range(0, int'(pow10(rdig) - 1)), rdig,
                     {$urandom, $urandom}, an,
                     {$urandom, $urandom}, dn, ft);
            put_gap($urandom_range(0, 3));
        end
        run_stream();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
